// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and hands each register/value entry to the SCCB write master.
// Define OV7670_CFG_FAST_DELAY_EN to shorten every 16'hFFF0 delay entry to 16 cycles.
module ov7670_config_sequencer #(
    parameter int unsigned DELAY_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BASE_W = $clog2(DELAY_CYCLES + 1);
`ifdef OV7670_CFG_FAST_DELAY_EN
    localparam int unsigned CNT_W      = (BASE_W < 4) ? 4 : BASE_W;
    localparam int unsigned DELAY_LOAD = 15;
`else
    localparam int unsigned CNT_W      = BASE_W;
    localparam int unsigned DELAY_LOAD = DELAY_CYCLES - 1;
`endif
    localparam logic [CNT_W-1:0] DELAY_LOAD_V = CNT_W'(DELAY_LOAD);
    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, SEND, WAIT_LO, WAIT_HI, DELAY, DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       rom_addr_reg, rom_addr_next;
    logic             sccb_start_reg, sccb_start_next;
    logic [7:0]       sccb_reg_reg, sccb_reg_next;
    logic [7:0]       sccb_data_reg, sccb_data_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [CNT_W-1:0] delay_cnt_reg, delay_cnt_next;

    logic at_last;
    assign at_last = (rom_addr_reg == 8'hFF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = FETCH;
            FETCH:      state_next = DECODE;
            DECODE: begin
                if (rom_dout == ENTRY_END)        state_next = DONE;
                else if (rom_dout == ENTRY_DELAY) state_next = DELAY;
                else                              state_next = SEND;
            end
            SEND:    if (sccb_ready)  state_next = WAIT_LO;
            WAIT_LO: if (!sccb_ready) state_next = WAIT_HI;
            WAIT_HI: if (sccb_ready)  state_next = at_last ? DONE : FETCH;
            DELAY:   if (delay_cnt_reg == '0) state_next = at_last ? DONE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs; the advance step never wraps past address 255.
    always_comb begin
        rom_addr_next   = rom_addr_reg;
        sccb_start_next = 1'b0;
        sccb_reg_next   = sccb_reg_reg;
        sccb_data_next  = sccb_data_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        delay_cnt_next  = delay_cnt_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    rom_addr_next = 8'h00;
                    done_next     = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            DECODE: begin
                if (rom_dout == ENTRY_END) begin
                    done_next = 1'b1;
                    busy_next = 1'b0;
                end else if (rom_dout == ENTRY_DELAY) begin
                    delay_cnt_next = DELAY_LOAD_V;
                end else begin
                    sccb_reg_next  = rom_dout[15:8];
                    sccb_data_next = rom_dout[7:0];
                end
            end
            SEND: begin
                if (sccb_ready) sccb_start_next = 1'b1;
            end
            WAIT_HI: begin
                if (sccb_ready) begin
                    if (at_last) begin
                        done_next = 1'b1;
                        busy_next = 1'b0;
                    end else begin
                        rom_addr_next = rom_addr_reg + 8'd1;
                    end
                end
            end
            DELAY: begin
                if (delay_cnt_reg == '0) begin
                    if (at_last) begin
                        done_next = 1'b1;
                        busy_next = 1'b0;
                    end else begin
                        rom_addr_next = rom_addr_reg + 8'd1;
                    end
                end else begin
                    delay_cnt_next = delay_cnt_reg - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_reg   <= 8'h00;
            sccb_start_reg <= 1'b0;
            sccb_reg_reg   <= 8'h00;
            sccb_data_reg  <= 8'h00;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            delay_cnt_reg  <= '0;
        end else begin
            rom_addr_reg   <= rom_addr_next;
            sccb_start_reg <= sccb_start_next;
            sccb_reg_reg   <= sccb_reg_next;
            sccb_data_reg  <= sccb_data_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            delay_cnt_reg  <= delay_cnt_next;
        end
    end

    assign rom_addr   = rom_addr_reg;
    assign sccb_start = sccb_start_reg;
    assign sccb_reg   = sccb_reg_reg;
    assign sccb_data  = sccb_data_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Scoreboard bench: a reference walk of the ROM image predicts every SCCB write; a monitor checks them.
module tb_ov7670_config_sequencer;

    localparam int TB_DELAY = 50;
`ifdef OV7670_CFG_FAST_DELAY_EN
    localparam int EXP_DELAY = 16;
`else
    localparam int EXP_DELAY = TB_DELAY;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sccb_ready;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        busy;
    logic        done;

    logic [15:0] rom_mem [256];
    logic [23:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_writes = 0;
    int first_start_cyc = -1;
    int ready_rise_cyc  = 0;
    int xfer_min = 2;
    int xfer_max = 6;
    int busy_cnt = 0;
    bit ready_block = 1'b0;
    bit prev_start  = 1'b0;

    ov7670_config_sequencer #(.DELAY_CYCLES(TB_DELAY)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .sccb_ready (sccb_ready),
        .sccb_start (sccb_start),
        .sccb_reg   (sccb_reg),
        .sccb_data  (sccb_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Registered ROM with one-edge read latency, plus an edge counter.
    always @(posedge clk) begin
        rom_dout <= rom_mem[rom_addr];
        cyc      <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // SCCB master: drops ready right after seeing a write request, busy for xfer_min..xfer_max cycles.
    initial begin
        sccb_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    sccb_ready     = 1'b1;
                    ready_rise_cyc = cyc;
                end
            end else if (sccb_start) begin
                sccb_ready = 1'b0;
                busy_cnt   = $urandom_range(xfer_max, xfer_min);
            end else begin
                sccb_ready = !ready_block;
            end
        end
    end

    // Monitor: every write request is popped against the reference model.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (sccb_start) begin
                n_writes++;
                if (first_start_cyc < 0) first_start_cyc = cyc;
                check("start_single_cycle", {31'b0, prev_start}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %02h reg %02h data %02h, expected no write",
                             rom_addr, sccb_reg, sccb_data);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr_reg_data", {8'h00, rom_addr, sccb_reg, sccb_data}, {8'h00, e});
                end
                $display("[TB] write addr=%02h reg=%02h data=%02h cyc=%0d", rom_addr, sccb_reg, sccb_data, cyc);
            end
            prev_start = sccb_start;
        end
    end

    // Reference model: walk from 0, skip delay entries, stop at the end marker or after address 255.
    task automatic build_expected(output int final_addr);
        final_addr = 255;
        for (int a = 0; a < 256; a++) begin
            if (rom_mem[a] == 16'hFFFF) begin
                final_addr = a;
                break;
            end
            if (rom_mem[a] != 16'hFFF0) exp_q.push_back({a[7:0], rom_mem[a]});
        end
    endtask

    task automatic random_write_entry(output logic [15:0] e);
        do e = 16'($urandom); while (e[15:4] == 12'hFFF);
    endtask

    task automatic begin_seq(output int start_cyc, output int fin);
        build_expected(fin);
        first_start_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("addr_after_start", {24'b0, rom_addr}, 32'd0);
        check("done_clear_after_start", {31'b0, done}, 32'd0);
    endtask

    task automatic finish_seq(input bit glitch, input int fin, output int done_cyc);
        int budget = 0;
        while (!done && budget < 30000) begin
            if (glitch && $urandom_range(20, 0) == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end else begin
                @(negedge clk);
            end
            budget++;
        end
        done_cyc = cyc;
        check("done_reached", {31'b0, done}, 32'd1);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        check("final_addr", {24'b0, rom_addr}, fin);
        check("all_writes_issued", exp_q.size(), 32'd0);
        exp_q.delete();
        $display("[TB] sequence done at addr=%02h cyc=%0d", rom_addr, cyc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rom_addr"}, {24'b0, rom_addr}, 32'd0);
        check({tag, "_sccb_start"}, {31'b0, sccb_start}, 32'd0);
        check({tag, "_sccb_reg"}, {24'b0, sccb_reg}, 32'd0);
        check({tag, "_sccb_data"}, {24'b0, sccb_data}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, fin, dc, base, bad, budget, r;
        logic [15:0] e0;
        reset_n = 1'b0;
        start   = 1'b0;
        for (int a = 0; a < 256; a++) rom_mem[a] = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Single write then end; done two edges after the edge that first sees ready high.
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'hFFFF;
        xfer_min = 20; xfer_max = 20;
        base = n_writes;
        begin_seq(s, fin);
        finish_seq(1'b0, fin, dc);
        check("one_write", n_writes - base, 32'd1);
        check("done_after_ready", dc, ready_rise_cyc + 1 + 2);

        // Delay entry: DECODE at s+2, EXP_DELAY cycles in DELAY, then FETCH/DECODE/SEND.
        rom_mem[0] = 16'hFFF0;
        rom_mem[1] = 16'h1101;
        rom_mem[2] = 16'hFFFF;
        xfer_min = 3; xfer_max = 3;
        begin_seq(s, fin);
        finish_seq(1'b0, fin, dc);
        check("delay_write_timing", first_start_cyc, s + 2 + EXP_DELAY + 3);

        // Ready held low for 100 cycles before the first write.
        random_write_entry(e0);
        rom_mem[0] = e0;
        for (int a = 1; a < 5; a++) begin
            random_write_entry(rom_mem[a]);
        end
        rom_mem[5] = 16'hFFFF;
        xfer_min = 1; xfer_max = 4;
        ready_block = 1'b1;
        repeat (2) @(negedge clk);
        begin_seq(s, fin);
        while (cyc < s + 2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (sccb_start || sccb_reg != e0[15:8] || sccb_data != e0[7:0]) bad++;
            @(negedge clk);
        end
        check("blocked_bad_samples", bad, 32'd0);
        ready_block = 1'b0;
        finish_seq(1'b0, fin, dc);

        // Random ROM images with start pulses while busy; back-to-back runs restart from DONE.
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < 256; a++) begin
                r = $urandom_range(99, 0);
                if (r < 4)      rom_mem[a] = 16'hFFF0;
                else if (r < 6) rom_mem[a] = 16'hFFFF;
                else            rom_mem[a] = 16'($urandom);
            end
            rom_mem[$urandom_range(60, 10)] = 16'hFFFF;
            xfer_min = 1; xfer_max = 8;
            for (int k = 0; k < 2; k++) begin
                begin_seq(s, fin);
                finish_seq(1'b1, fin, dc);
            end
        end

        // Reset in WAIT_HI of the third write, then replay from entry 0.
        for (int a = 0; a < 8; a++) begin
            random_write_entry(rom_mem[a]);
        end
        rom_mem[8] = 16'hFFFF;
        xfer_min = 10; xfer_max = 10;
        base = n_writes;
        begin_seq(s, fin);
        budget = 0;
        while (n_writes - base < 3 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check("third_write_seen", n_writes - base, 32'd3);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        base = n_writes;
        begin_seq(s, fin);
        finish_seq(1'b0, fin, dc);
        check("replay_write_count", n_writes - base, 32'd8);

        // 0x0101 everywhere: 256 writes, ends at address 255 without wrapping.
        for (int a = 0; a < 256; a++) rom_mem[a] = 16'h0101;
        xfer_min = 1; xfer_max = 2;
        base = n_writes;
        begin_seq(s, fin);
        finish_seq(1'b0, fin, dc);
        check("full_rom_writes", n_writes - base, 32'd256);
        repeat (5) @(negedge clk);
        check("no_wrap_addr", {24'b0, rom_addr}, 32'd255);
        check("still_done", {31'b0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_config_sequencer.md
# ov7670_config_sequencer

Walks the OV7670 configuration ROM from address 0, decodes each 16-bit entry and hands register/value pairs to the SCCB master one at a time. Entry 16'hFFF0 inserts a fixed delay and 16'hFFFF terminates the sequence. The block sits between the config ROM (registered, 1-cycle read latency) and the SCCB write master, and is started once after power-up or on a user reconfigure request.

## Interface
- DELAY_CYCLES, 1_000_000, clk cycles spent on a 16'hFFF0 entry (10 ms at 100 MHz)
- clk  in  1  system clock; ROM and SCCB master share it
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to run the sequence from ROM address 0
- rom_addr  out  8  ROM address
- rom_dout  in  16  ROM data, valid one clk edge after rom_addr changes
- sccb_ready  in  1  SCCB master idle and able to accept a write
- sccb_start  out  1  single-cycle write request to SCCB master
- sccb_reg  out  8  register address for the write (rom_dout[15:8])
- sccb_data  out  8  register value for the write (rom_dout[7:0])
- busy  out  1  sequence in progress
- done  out  1  sequence finished; held until next accepted start

## Operation
- States: IDLE, FETCH, DECODE, SEND, WAIT_LO, WAIT_HI, DELAY, DONE.
- IDLE/DONE: start=1 -> rom_addr<=0, done<=0, busy<=1, FETCH. start ignored in any other state.
- FETCH: one cycle of ROM latency -> DECODE.
- DECODE on rom_dout:
  - 16'hFFFF -> DONE (done<=1, busy<=0).
  - 16'hFFF0 -> load delay counter with DELAY_CYCLES-1 -> DELAY.
  - else latch sccb_reg/sccb_data -> SEND.
- SEND: wait for sccb_ready=1; then sccb_start=1 for exactly one cycle -> WAIT_LO.
- WAIT_LO: wait for sccb_ready=0 (master accepted) -> WAIT_HI.
- WAIT_HI: wait for sccb_ready=1 (write complete) -> advance.
- DELAY: decrement each cycle; at 0 -> advance.
- Advance: rom_addr=255 -> DONE (no wrap); else rom_addr<=rom_addr+1 -> FETCH.
- Entry 16'h0000 (ROM held in reset) is a normal write of reg 0x00 = 0x00; no special case.
- sccb_reg/sccb_data stay stable from SEND entry until the next DECODE.
- Delay counter width $clog2(DELAY_CYCLES+1); DELAY_CYCLES >= 1.

## Timing
- Reset values: rom_addr=0, sccb_start=0, sccb_reg=0, sccb_data=0, busy=0, done=0, state IDLE.
- All outputs registered.
- start sampled at edge N: busy=1 and rom_addr=0 after edge N; DECODE at edge N+2.
- Write entry with sccb_ready already high: sccb_start high in the cycle after DECODE (edge N+3 to N+4).
- Per-write overhead excluding SCCB transfer time: 4 cycles (FETCH, DECODE, SEND, advance edge merged with WAIT_HI exit).
- Delay entry occupies DELAY_CYCLES cycles in DELAY.
- End entry: done=1 and busy=0 after the edge that decodes 16'hFFFF.
- reset_n low mid-sequence: immediate return to reset values and IDLE. sccb_start never left high.
- sccb_ready stuck high after sccb_start: block waits in WAIT_LO indefinitely. The SCCB master must drop ready within one cycle of accepting a write.

## Configuration
- OV7670_CFG_FAST_DELAY_EN defined: DELAY state lasts 16 cycles regardless of DELAY_CYCLES. Used for simulation speed.
- Not defined: DELAY lasts DELAY_CYCLES cycles.
- No other behaviour differs.

## Test plan
- ROM model {0:16'h1280, 1:16'hFFFF}, master model with ready low for 20 cycles after start -> exactly one sccb_start with reg=0x12, data=0x80; done=1 and busy=0 two cycles after ready returns high.
- ROM {0:16'hFFF0, 1:16'h1101, 2:FFFF}, DELAY_CYCLES=50 (macro off) -> sccb_start for 0x11/0x01 occurs no earlier than 50 cycles after first DECODE. With macro on -> after 16 cycles.
- sccb_ready held low for 100 cycles before the first write -> sccb_start stays 0 until ready rises, then pulses once; reg/data stable throughout.
- start pulsed while busy -> no restart, rom_addr sequence unchanged. start in DONE -> done clears and rom_addr restarts at 0.
- reset_n asserted during WAIT_HI of the third write -> all outputs zero that cycle. New start replays from entry 0.
- ROM returning 16'h0101 at all 256 addresses -> 256 writes issued, then done=1 at rom_addr=255 with no wrap to 0.
